// File: rtl/sync_xfer_sequencer_if.sv
// Requester/destination-facing bundle of the synchronizer transfer sequencer.
// master = requester/destination side, slave = sequencer side.
interface sync_xfer_sequencer_if #(
  parameter int DW = 8
);
  logic          mode_req;
  logic [2:0]    mode_in;
  logic          mode_busy;
  logic [2:0]    sel;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_ready;
  logic [DW-1:0] data_out;
  logic          stb;
  logic          ack_async;
  logic [7:0]    done_cnt;
  logic          err;

  modport master (
    output mode_req, mode_in, tx_valid, tx_data, ack_async,
    input  mode_busy, sel, tx_ready, data_out, stb, done_cnt, err
  );

  modport slave (
    input  mode_req, mode_in, tx_valid, tx_data, ack_async,
    output mode_busy, sel, tx_ready, data_out, stb, done_cnt, err
  );
endinterface

// File: rtl/sync_xfer_sequencer.sv
// Source-side sequencer for the 4-mode synchronizer: fixed-window holds in modes 0-2,
// four-phase stb/ack with per-phase timeout in mode 3, mode changes applied only when idle.
module sync_xfer_sequencer #(
  parameter int DW         = 8,
  parameter int STB_CYCLES = 4,
  parameter int GUARD      = 3,
  parameter int TIMEOUT    = 15
) (
  input logic                  clk,
  input logic                  rst,
  sync_xfer_sequencer_if.slave bus
);

  localparam int CMAX = (TIMEOUT > STB_CYCLES) ?
                        ((TIMEOUT > GUARD) ? TIMEOUT : GUARD) :
                        ((STB_CYCLES > GUARD) ? STB_CYCLES : GUARD);
  localparam int CW   = $clog2(CMAX);

  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_REQ, S_REL, S_GUARD} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          pend_vld, pend_vld_nxt;
  logic [1:0]    pend_mode, pend_mode_nxt;
  logic [2:0]    sel_q, sel_nxt;
  logic          stb_q, stb_nxt;
  logic [DW-1:0] data_q, data_nxt;
  logic [7:0]    done_q, done_nxt;
  logic          err_q, err_nxt;
  logic [1:0]    ack_ff;
  logic          ack_s;
  logic          tx_ready;
  logic          accept;
  logic          phase_to;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ack_ff <= '0;
    else     ack_ff <= {ack_ff[0], bus.ack_async};
  end
  assign ack_s = ack_ff[1];

  // Pending mode takes priority over a new word: tx_ready is already low while pending.
  assign tx_ready = (state == S_IDLE) & ~pend_vld & ~rst;
  assign accept   = bus.tx_valid & tx_ready;
  assign phase_to = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    pend_vld_nxt  = pend_vld;
    pend_mode_nxt = pend_mode;
    sel_nxt       = sel_q;
    stb_nxt       = stb_q;
    data_nxt      = data_q;
    done_nxt      = done_q;
    err_nxt       = err_q;
    case (state)
      S_IDLE: begin
        if (pend_vld) begin
          sel_nxt      = {1'b0, pend_mode};
          pend_vld_nxt = 1'b0;
          cnt_nxt      = CW'(GUARD - 1);
          state_nxt    = S_GUARD;
        end else if (accept) begin
          data_nxt = bus.tx_data;
          if (sel_q == 3'd3) begin
            cnt_nxt   = '0;
            stb_nxt   = 1'b1;
            state_nxt = S_REQ;
          end else begin
            cnt_nxt   = CW'(STB_CYCLES - 1);
            state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (cnt == '0) begin
          done_nxt  = done_q + 8'd1;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_REQ: begin
        if (ack_s) begin
          stb_nxt   = 1'b0;
          cnt_nxt   = '0;
          state_nxt = S_REL;
        end else if (phase_to) begin
          err_nxt   = 1'b1;
          stb_nxt   = 1'b0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_REL: begin
        if (!ack_s) begin
          done_nxt  = done_q + 8'd1;
          state_nxt = S_IDLE;
        end else if (phase_to) begin
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_GUARD: begin
        if (cnt == '0) state_nxt = S_IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: begin
        stb_nxt   = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
    // A request arriving on the same edge the previous one is applied re-arms pending.
    if (bus.mode_req) begin
      if (bus.mode_in[2]) begin
        err_nxt = 1'b1;
      end else begin
        pend_vld_nxt  = 1'b1;
        pend_mode_nxt = bus.mode_in[1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      pend_vld  <= 1'b0;
      pend_mode <= '0;
      sel_q     <= '0;
      stb_q     <= 1'b0;
      data_q    <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      pend_vld  <= pend_vld_nxt;
      pend_mode <= pend_mode_nxt;
      sel_q     <= sel_nxt;
      stb_q     <= stb_nxt;
      data_q    <= data_nxt;
      done_q    <= done_nxt;
      err_q     <= err_nxt;
    end
  end

  assign bus.tx_ready  = tx_ready;
  assign bus.mode_busy = pend_vld | (state == S_GUARD);
  assign bus.sel       = sel_q;
  assign bus.stb       = stb_q;
  assign bus.data_out  = data_q;
  assign bus.done_cnt  = done_q;
  assign bus.err       = err_q;

  a_stb_only_req: assert property (@(posedge clk) disable iff (rst) stb_q |-> state == S_REQ);
  a_sel_stable:   assert property (@(posedge clk) disable iff (rst) (state != S_IDLE) |=> $stable(sel_q));
  a_data_stable:  assert property (@(posedge clk) disable iff (rst) (state != S_IDLE) |=> $stable(data_q));

endmodule

// File: tb/tb_sync_xfer_sequencer.sv
// Scoreboard bench for sync_xfer_sequencer: expected words pushed on accept, popped on done_cnt change.
module tb_sync_xfer_sequencer;
  localparam int DW  = 8;
  localparam int STB = 4;
  localparam int GRD = 3;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_xfer_sequencer_if #(.DW(DW)) ifc();
  sync_xfer_sequencer #(.DW(DW), .STB_CYCLES(STB), .GUARD(GRD), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .bus(ifc)
  );

  logic ack_follow = 1'b0;
  logic ack_force  = 1'b0;
  assign ifc.ack_async = ack_follow ? ifc.stb : ack_force;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] exp_done  = '0;
  logic [7:0] prev_done = '0;
  int         n_chk = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Completion monitor: each done_cnt step must match the oldest outstanding word.
  always @(negedge clk) begin
    if (rst) begin
      prev_done = '0;
    end else if (ifc.done_cnt != prev_done) begin
      if (sb.size() == 0) begin
        chk("unexp_done", {24'd0, ifc.done_cnt}, {24'd0, prev_done});
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_data", {24'd0, ifc.data_out}, {24'd0, e.data});
        chk("sb_cnt",  {24'd0, ifc.done_cnt}, {24'd0, e.cnt});
      end
      prev_done = ifc.done_cnt;
    end
  end

  task automatic accept(input logic [7:0] d, input bit expect_done);
    int n = 0;
    @(negedge clk);
    while (!ifc.tx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(n < 100), 32'd1);
    ifc.tx_valid = 1'b1;
    ifc.tx_data  = d;
    if (expect_done) begin
      exp_done++;
      sb.push_back('{data: d, cnt: exp_done});
    end
    @(negedge clk);
    ifc.tx_valid = 1'b0;
  endtask

  task automatic low_ready(output int low, output int stb_hi);
    low = 0;
    stb_hi = 0;
    while (!ifc.tx_ready && low < 100) begin
      low++;
      if (ifc.stb) stb_hi++;
      @(negedge clk);
    end
  endtask

  task automatic req_mode(input logic [2:0] m);
    @(negedge clk);
    ifc.mode_req = 1'b1;
    ifc.mode_in  = m;
    @(negedge clk);
    ifc.mode_req = 1'b0;
  endtask

  task automatic wait_not_busy(output int n);
    n = 0;
    while (ifc.mode_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    exp_done = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int low, sh, n;
    logic [7:0] d0;
    ifc.mode_req = 1'b0;
    ifc.mode_in  = '0;
    ifc.tx_valid = 1'b0;
    ifc.tx_data  = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_sel",   {29'd0, ifc.sel}, 32'd0);
    chk("rst_stb",   {31'd0, ifc.stb}, 32'd0);
    chk("rst_data",  {24'd0, ifc.data_out}, 32'd0);
    chk("rst_done",  {24'd0, ifc.done_cnt}, 32'd0);
    chk("rst_err",   {31'd0, ifc.err}, 32'd0);
    chk("rst_ready", {31'd0, ifc.tx_ready}, 32'd0);
    chk("rst_busy",  {31'd0, ifc.mode_busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, ifc.tx_ready}, 32'd1);

    // Mode 0 transfer
    accept(8'h55, 1'b1);
    chk("m0_data", {24'd0, ifc.data_out}, 32'h55);
    low_ready(low, sh);
    chk("m0_low", low, STB);
    chk("m0_stb", sh, 0);
    chk("m0_done", {24'd0, ifc.done_cnt}, 32'd1);

    // Mode change to 3, then zero-delay ack transfer
    req_mode(3'd3);
    chk("mc_sel_old", {29'd0, ifc.sel}, 32'd0);
    wait_not_busy(n);
    chk("mc_busy_len", n, 1 + GRD);
    chk("mc_sel_new", {29'd0, ifc.sel}, 32'd3);
    chk("mc_ready", {31'd0, ifc.tx_ready}, 32'd1);
    ack_follow = 1'b1;
    accept(8'hFF, 1'b1);
    low_ready(low, sh);
    chk("m3_low", low, 6);
    chk("m3_stb", sh, 3);
    chk("m3_done", {24'd0, ifc.done_cnt}, 32'd2);

    // Mode requests while in REQ: only the last one is applied, after REL exits
    ack_follow = 1'b0;
    ack_force  = 1'b0;
    accept(8'h3C, 1'b1);
    req_mode(3'd1);
    req_mode(3'd2);
    chk("req_sel_hold", {29'd0, ifc.sel}, 32'd3);
    chk("req_busy", {31'd0, ifc.mode_busy}, 32'd1);
    chk("req_stb", {31'd0, ifc.stb}, 32'd1);
    ack_force = 1'b1;
    n = 0;
    while (ifc.stb && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ack_seen", 32'(n < 20), 32'd1);
    chk("rel_sel_hold", {29'd0, ifc.sel}, 32'd3);
    ack_force = 1'b0;
    d0 = ifc.done_cnt;
    n = 0;
    while (ifc.done_cnt == d0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rel_exit_seen", 32'(n < 20), 32'd1);
    chk("rel_exit_sel", {29'd0, ifc.sel}, 32'd3);
    @(negedge clk);
    chk("pend_applied", {29'd0, ifc.sel}, 32'd2);
    chk("pend_guard_busy", {31'd0, ifc.mode_busy}, 32'd1);
    wait_not_busy(n);

    // Ack stuck low in mode 3: timeout
    req_mode(3'd3);
    wait_not_busy(n);
    chk("to_err_before", {31'd0, ifc.err}, 32'd0);
    d0 = ifc.done_cnt;
    accept(8'hA5, 1'b0);
    low_ready(low, sh);
    chk("to_low", low, TMO);
    chk("to_stb", sh, TMO);
    chk("to_err", {31'd0, ifc.err}, 32'd1);
    chk("to_done", {24'd0, ifc.done_cnt}, {24'd0, d0});
    chk("to_ready", {31'd0, ifc.tx_ready}, 32'd1);

    // Invalid mode after a fresh reset
    do_reset();
    @(negedge clk);
    chk("inv_err_before", {31'd0, ifc.err}, 32'd0);
    req_mode(3'd5);
    chk("inv_err", {31'd0, ifc.err}, 32'd1);
    chk("inv_busy", {31'd0, ifc.mode_busy}, 32'd0);
    @(negedge clk);
    chk("inv_sel", {29'd0, ifc.sel}, 32'd0);
    chk("inv_ready", {31'd0, ifc.tx_ready}, 32'd1);

    // 256 mode-0 transfers wrap done_cnt
    for (int i = 0; i < 256; i++) begin
      accept(8'(i * 7 + 1), 1'b1);
      low_ready(low, sh);
    end
    chk("wrap_low", low, STB);
    chk("wrap_done", {24'd0, ifc.done_cnt}, 32'd0);
    accept(8'h11, 1'b1);
    low_ready(low, sh);
    chk("post_wrap_done", {24'd0, ifc.done_cnt}, 32'd1);

    // Reset in the middle of REQ
    req_mode(3'd3);
    wait_not_busy(n);
    accept(8'h99, 1'b0);
    repeat (3) @(negedge clk);
    chk("mid_stb_pre", {31'd0, ifc.stb}, 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_stb",   {31'd0, ifc.stb}, 32'd0);
    chk("mid_sel",   {29'd0, ifc.sel}, 32'd0);
    chk("mid_data",  {24'd0, ifc.data_out}, 32'd0);
    chk("mid_done",  {24'd0, ifc.done_cnt}, 32'd0);
    chk("mid_err",   {31'd0, ifc.err}, 32'd0);
    chk("mid_ready", {31'd0, ifc.tx_ready}, 32'd0);
    chk("mid_busy",  {31'd0, ifc.mode_busy}, 32'd0);
    sb.delete();
    exp_done = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("sb_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/sync_xfer_sequencer.md
# sync_xfer_sequencer

Single-clock controller that sequences the 4-mode synchronizer's configuration and source-side transfers. It accepts 8-bit words from a local ready/valid requester and presents them on the synchronizer data inputs. In mode 3 it runs a four-phase stb/ack handshake with a timeout; in modes 0–2 it holds each word for a fixed window. Mode (`sel`) changes are applied only when no transfer is in flight, followed by a guard interval.

## Interface
- `DW`, 8: data width.
- `STB_CYCLES`, 4: hold cycles per word in modes 0–2 (≥1).
- `GUARD`, 3: idle cycles after every `sel` change (≥1).
- `TIMEOUT`, 15: max cycles in each mode-3 handshake phase (≥3).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `mode_req`  in  1  single-cycle request to change mode.
- `mode_in`  in  3  requested mode; valid range 0–3.
- `mode_busy`  out  1  mode change pending or in guard interval.
- `sel`  out  3  synchronizer mode select.
- `tx_valid`  in  1  requester has a word.
- `tx_data`  in  DW  word to send.
- `tx_ready`  out  1  controller accepts a word this cycle.
- `data_out`  out  DW  word driven to the synchronizer.
- `stb`  out  1  mode-3 data-valid strobe.
- `ack_async`  in  1  destination acknowledge; asynchronous to `clk`, synchronized internally.
- `done_cnt`  out  8  completed transfers; wraps 255→0.
- `err`  out  1  sticky error flag; cleared only by reset.

## Operation
- **Acknowledge sync:** 2-FF synchronizer, `ack_async`→`ack_s`, both stages reset to 0.
- **States:** IDLE, HOLD, REQ, REL, GUARD.
- **Decoded outputs:** `tx_ready` = (state==IDLE) & ~pending & ~rst. `mode_busy` = pending | (state==GUARD).
- **IDLE + pending:**
  - `sel` ← pending value; clear pending.
  - Go to GUARD and load the guard counter.
  - Pending beats `tx_valid` because `tx_ready` is already 0.
- **IDLE + handshake (`tx_valid & tx_ready`):**
  - Register `data_out` ← `tx_data`.
  - If `sel`==3, go to REQ with `stb` = 1.
  - Otherwise go to HOLD.
- **HOLD:** stay `STB_CYCLES` cycles, then IDLE; increment `done_cnt`; `stb` stays 0.
- **REQ:** on the first edge with `ack_s`==1, drop `stb` and go to REL.
- **REL:** on the first edge with `ack_s`==0, go to IDLE; increment `done_cnt`.
- **Timeout:**
  - Applies when the exit condition of REQ or REL has not occurred by the `TIMEOUT`-th edge in that state.
  - Set `err`, force `stb` = 0, go to IDLE.
  - `done_cnt` unchanged.
  - The phase counter restarts on every state entry.
- **GUARD:** stay `GUARD` cycles with `tx_ready` = 0, then IDLE.
- **Mode requests:**
  - `mode_req` with `mode_in` ≤ 3 latches the pending value in any state.
  - A later request overwrites the pending value before it is applied.
  - `mode_in` > 3: request ignored, `err` set.
- **Invariants:**
  - `sel` never changes while in HOLD, REQ or REL.
  - `stb` is 1 only in REQ.
  - `data_out` is stable from accept until return to IDLE.
- **Reset:**
  - Values: `sel`=0, `stb`=0, `data_out`=0, `done_cnt`=0, `err`=0, pending cleared, state IDLE, `tx_ready`=0, `mode_busy`=0.
  - Reset mid-transfer aborts at once; `stb` falls asynchronously.

## Timing
- All registered outputs update on `clk` rising edge; `tx_ready` and `mode_busy` are decoded from registers only.
- Mode 0–2 transfer accepted at edge k:
  - `tx_ready` = 0 until edge k+`STB_CYCLES`.
  - `done_cnt` increments at that edge; next accept possible at edge k+`STB_CYCLES`+1.
- Mode 3 with `ack_async` = `stb` (zero delay), accept at edge k:
  - `stb` high from k to k+3.
  - `done_cnt` increments at edge k+6; next accept at edge k+7.
- Mode change, `mode_req` at edge m while IDLE and not busy:
  - `sel` updates at edge m+1.
  - `mode_busy` high after edge m until edge m+1+`GUARD`; `tx_ready` high after it.
- Same-edge `mode_req` and accepted transfer: the transfer completes first, then the mode is applied.

## Test plan
- **Reset, then mode 0:** reset, `sel`=0, send 0x55 → `data_out`=0x55 at k+1; `tx_ready` low 4 cycles; `done_cnt`=1; `stb` never high.
- **Mode change to 3, then one transfer:** `mode_req` with 3 → `sel`=3 one edge later, `mode_busy` high 4 cycles. Then send 0xFF with `ack_async`=`stb` → `stb` high 3 cycles, `done_cnt` +1 at k+6.
- **Ack stuck low in mode 3:** → `stb` drops at edge k+15, `err`=1, `done_cnt` unchanged, `tx_ready` high again.
- **Mode request during REQ:** `mode_req`=2 while in REQ → `sel` stays 3 until REL exits, then 2. Two requests (1 then 2) before the change applies → only 2 applied.
- **Invalid mode:** `mode_in`=5 → `sel` unchanged, `err`=1.
- **Counter wrap and mid-transfer reset:** 256 transfers → `done_cnt` wraps to 0. Assert `rst` mid-REQ → `stb`=0 immediately; all outputs at reset values.
